// File: rtl/trap_ctrl_if.sv
// trap_ctrl_if: pipeline/CSR-facing signal bundle of the trap sequencer.
//   slave  - used by trap_ctrl (consumes requests and CSR state, drives
//            acks, strobes, flush and redirect).
//   master - used by the pipeline/CSR side.
// Interrupt lines, clk and rst are plain ports on trap_ctrl.
interface trap_ctrl_if;
  logic        exc_req;
  logic [31:0] exc_cause;
  logic [31:0] exc_pc;
  logic        exc_ack;
  logic        mret_req;
  logic        mret_ack;
  logic [31:0] commit_pc;
  logic        pipe_drained;
  logic        csr_interrupt_en;
  logic [31:0] csr_mie;
  logic [1:0]  csr_mtvec_mode;
  logic [29:0] csr_mtvec_base;
  logic [31:0] csr_mepc;
  logic [31:0] mip_val;
  logic        csr_exception;
  logic [31:0] csr_exception_cause;
  logic [31:0] csr_exception_pc;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        busy;

  modport slave (
    input  exc_req, exc_cause, exc_pc, mret_req, commit_pc, pipe_drained,
           csr_interrupt_en, csr_mie, csr_mtvec_mode, csr_mtvec_base, csr_mepc,
    output exc_ack, mret_ack, mip_val, csr_exception, csr_exception_cause,
           csr_exception_pc, flush, redirect, redirect_pc, busy
  );

  modport master (
    output exc_req, exc_cause, exc_pc, mret_req, commit_pc, pipe_drained,
           csr_interrupt_en, csr_mie, csr_mtvec_mode, csr_mtvec_base, csr_mepc,
    input  exc_ack, mret_ack, mip_val, csr_exception, csr_exception_cause,
           csr_exception_pc, flush, redirect, redirect_pc, busy
  );
endinterface

// File: rtl/trap_ctrl.sv
// trap_ctrl: trap sequencer between the pipeline and the CSR block.
// Synchronizes the interrupt lines into mip_val, arbitrates exception >
// interrupt > mret in IDLE, holds flush until the pipeline drains, then
// issues a one-cycle trap strobe to the CSR block plus a fetch redirect.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   irq_ext/irq_timer/irq_soft   asynchronous interrupt levels
//   bus (trap_ctrl_if.slave)     exception/mret handshakes, drain status,
//                                CSR inputs, mip_val, CSR trap strobe,
//                                flush, redirect, busy
//
// Parameters:
//   SYNC_STAGES       synchronizer depth per interrupt line (1-4)
//   RESET_VEC_UNUSED  reserved, must be 0
//
// Build option: define TRAP_CTRL_VECTORED_EN to enable vectored interrupt
// targets (mtvec mode 1). Without it every trap targets the mtvec base.
module trap_ctrl #(
  parameter int unsigned SYNC_STAGES      = 2,
  parameter int unsigned RESET_VEC_UNUSED = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       irq_ext,
  input  logic       irq_timer,
  input  logic       irq_soft,
  trap_ctrl_if.slave bus
);

  if (SYNC_STAGES < 1 || SYNC_STAGES > 4 || RESET_VEC_UNUSED != 0) begin : g_bad_param
    $error("trap_ctrl: illegal parameter value");
  end

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_TRAP  = 2'd2;
  localparam logic [1:0] ST_MRET  = 2'd3;

  localparam logic [31:0] CAUSE_EXT   = 32'h8000_000B;
  localparam logic [31:0] CAUSE_SOFT  = 32'h8000_0003;
  localparam logic [31:0] CAUSE_TIMER = 32'h8000_0007;

  // {ext, soft, timer} per stage
  logic [2:0]  sync_q [SYNC_STAGES];
  logic [2:0]  irq_lvl;
  logic [31:0] mip;
  logic [31:0] pend;
  logic        irq_eligible;
  logic [31:0] irq_cause;

  logic [1:0]  state_q;
  logic [31:0] cause_q;
  logic [31:0] epc_q;
  logic        irq_q;
  logic [31:0] trap_target;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {irq_ext, irq_soft, irq_timer};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign irq_lvl = sync_q[SYNC_STAGES-1];
  assign mip     = {20'b0, irq_lvl[2], 3'b0, irq_lvl[0], 3'b0, irq_lvl[1], 3'b0};
  assign pend    = mip & bus.csr_mie;
  assign irq_eligible = bus.csr_interrupt_en && (pend != '0);

  always_comb begin
    irq_cause = CAUSE_TIMER;
    if (pend[11])     irq_cause = CAUSE_EXT;
    else if (pend[3]) irq_cause = CAUSE_SOFT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cause_q <= '0;
      epc_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.exc_req) begin
            cause_q <= bus.exc_cause;
            epc_q   <= bus.exc_pc;
            irq_q   <= 1'b0;
            state_q <= ST_FLUSH;
          end else if (irq_eligible) begin
            // cause is fixed here; later irq/mie changes cannot cancel it
            cause_q <= irq_cause;
            irq_q   <= 1'b1;
            state_q <= ST_FLUSH;
          end else if (bus.mret_req) begin
            state_q <= ST_MRET;
          end
        end
        ST_FLUSH: begin
          if (bus.pipe_drained) begin
            if (irq_q) epc_q <= bus.commit_pc;
            state_q <= ST_TRAP;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef TRAP_CTRL_VECTORED_EN
  always_comb begin
    trap_target = {bus.csr_mtvec_base, 2'b00};
    if (irq_q && bus.csr_mtvec_mode == 2'd1)
      trap_target = {bus.csr_mtvec_base, 2'b00} + {25'b0, cause_q[4:0], 2'b00};
  end
`else
  logic mode_unused;
  assign mode_unused = ^bus.csr_mtvec_mode;
  assign trap_target = {bus.csr_mtvec_base, 2'b00};
`endif

  always_comb begin
    bus.mip_val             = mip;
    bus.busy                = (state_q != ST_IDLE);
    bus.flush               = 1'b0;
    bus.csr_exception       = 1'b0;
    bus.csr_exception_cause = '0;
    bus.csr_exception_pc    = '0;
    bus.redirect            = 1'b0;
    bus.redirect_pc         = '0;
    bus.exc_ack             = 1'b0;
    bus.mret_ack            = 1'b0;
    case (state_q)
      ST_FLUSH: bus.flush = 1'b1;
      ST_TRAP: begin
        bus.csr_exception       = 1'b1;
        bus.csr_exception_cause = cause_q;
        bus.csr_exception_pc    = epc_q;
        bus.redirect            = 1'b1;
        bus.redirect_pc         = trap_target;
        bus.exc_ack             = ~irq_q;
      end
      ST_MRET: begin
        bus.redirect    = 1'b1;
        bus.redirect_pc = bus.csr_mepc;
        bus.mret_ack    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
